// File: rtl/rgmii_pkg.sv
// rgmii_pkg
//   Shared types and constants for the RGMII receive decoder.
//   - rx_state_t   : frame FSM states
//   - link_speed_t : in-band speed codes (00 = 10, 01 = 100, 10 = 1000)
//   - PREAMBLE_BYTE / SFD_BYTE : preamble filler and start-of-frame delimiter
//   - sat_inc      : 16-bit saturating increment used by the length counter
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } link_speed_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rgmii_nibble_packer.sv
// rgmii_nibble_packer
//   Turns the IDDR nibble pair into bytes.
//   1000 mode: one byte per dv cycle, {fall, rise}.
//   10/100 mode: rise nibbles packed low-first, a byte every second dv cycle.
// Ports:
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_speed1000      : effective speed for this cycle (1 = byte per cycle)
//   i_dv             : RX_DV
//   i_rxd_rise/fall  : nibbles from the IDDR
//   o_byte           : assembled byte (combinational, qualified by o_byte_valid)
//   o_byte_valid     : a byte completes this cycle
//   o_odd            : a low nibble is pending (odd nibble count so far)
module rgmii_nibble_packer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_speed1000,
    input  logic       i_dv,
    input  logic [3:0] i_rxd_rise,
    input  logic [3:0] i_rxd_fall,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_odd
);

    logic       r_phase;
    logic [3:0] r_low;

    always_comb begin
        if (i_speed1000) begin
            o_byte       = {i_rxd_fall, i_rxd_rise};
            o_byte_valid = i_dv;
        end else begin
            o_byte       = {i_rxd_rise, r_low};
            o_byte_valid = i_dv & r_phase;
        end
    end

    assign o_odd = r_phase;

    // Phase restarts whenever dv is low, so the first nibble after a dv rise
    // always lands in the low half.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= 1'b0;
            r_low   <= '0;
        end else if (!i_dv || i_speed1000) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) r_low <= i_rxd_rise;
        end
    end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// rgmii_rx_decoder
//   RGMII receive frame decoder: strips preamble/SFD, delivers frame bytes
//   with a one-byte hold buffer so the last byte can carry end/err/len.
//   Optional in-band link status decode: define RGMII_INBAND_STATUS_EN.
// Parameters:
//   P_STRIP_PREAMBLE : 1 = drop preamble/SFD, 0 = deliver everything from dv rise
//   P_MAX_LEN        : maximum delivered bytes per frame (64..65535)
// Ports:
//   i_clk, i_rst_n            : RX clock, async active-low reset
//   i_speed1000               : 1 = 1000 mode, 0 = 10/100 (sampled only in IDLE)
//   i_rxd_rise, i_rxd_fall    : IDDR data nibbles
//   i_rxctl_rise, i_rxctl_fall: RX_DV and RX_DV^RX_ER
//   o_rx_data, o_rx_valid     : delivered byte
//   o_rx_end, o_rx_err, o_rx_len : last-byte marker, frame error, byte count
//   o_link_up, o_link_speed, o_full_duplex : in-band status (0 when disabled)
module rgmii_rx_decoder #(
    parameter int P_STRIP_PREAMBLE = 1,
    parameter int P_MAX_LEN        = 1522
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_speed1000,
    input  logic [3:0]  i_rxd_rise,
    input  logic [3:0]  i_rxd_fall,
    input  logic        i_rxctl_rise,
    input  logic        i_rxctl_fall,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_valid,
    output logic        o_rx_end,
    output logic        o_rx_err,
    output logic [15:0] o_rx_len,
    output logic        o_link_up,
    output logic [1:0]  o_link_speed,
    output logic        o_full_duplex
);

    import rgmii_pkg::*;

    localparam rx_state_t LP_FIRST_STATE = (P_STRIP_PREAMBLE != 0) ? ST_PREAMBLE : ST_DATA;

    rx_state_t   r_state;
    logic        r_speed;
    logic        r_armed;
    logic [7:0]  r_hold;
    logic        r_hold_valid;
    logic [15:0] r_count;
    logic        r_err;

    logic        w_dv;
    logic        w_er;
    logic        w_start;
    logic        w_speed;
    rx_state_t   w_cur;
    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        w_odd;
    logic [16:0] w_index;

    assign w_dv    = i_rxctl_rise;
    assign w_er    = i_rxctl_rise ^ i_rxctl_fall;
    // r_armed means dv was low last cycle: only a true dv rise starts a frame,
    // which also keeps a frame that was in flight across reset from being picked up.
    assign w_start = (r_state == ST_IDLE) && w_dv && r_armed;
    assign w_speed = (r_state == ST_IDLE) ? i_speed1000 : r_speed;
    // Position (1-based) of the byte completing now: delivered + held + this one.
    assign w_index = {1'b0, r_count} + {16'd0, r_hold_valid} + 17'd1;

    // The dv-rise cycle already carries frame data, so it is processed in the
    // state the frame is entering rather than in IDLE.
    always_comb begin
        w_cur = r_state;
        if (w_start) w_cur = LP_FIRST_STATE;
    end

    rgmii_nibble_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_speed1000  (w_speed),
        .i_dv         (w_dv),
        .i_rxd_rise   (i_rxd_rise),
        .i_rxd_fall   (i_rxd_fall),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_odd        (w_odd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_speed      <= 1'b0;
            r_armed      <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_count      <= '0;
            r_err        <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_rx_end     <= 1'b0;
            o_rx_err     <= 1'b0;
            o_rx_len     <= '0;
        end else begin
            o_rx_valid <= 1'b0;
            o_rx_end   <= 1'b0;
            o_rx_err   <= 1'b0;
            o_rx_len   <= '0;
            r_armed    <= ~w_dv;
            r_speed    <= w_speed;

            case (w_cur)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end

                ST_PREAMBLE: begin
                    if (!w_dv) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b0;
                    end else begin
                        r_err <= r_err | w_er;
                        if (w_byte_valid) begin
                            if (w_byte == SFD_BYTE)           r_state <= ST_DATA;
                            else if (w_byte == PREAMBLE_BYTE) r_state <= ST_PREAMBLE;
                            else                              r_state <= ST_DROP;
                        end else begin
                            r_state <= ST_PREAMBLE;
                        end
                    end
                end

                ST_DATA: begin
                    if (!w_dv) begin
                        if (r_hold_valid) begin
                            o_rx_data  <= r_hold;
                            o_rx_valid <= 1'b1;
                            o_rx_end   <= 1'b1;
                            o_rx_err   <= r_err | w_odd;
                            o_rx_len   <= sat_inc(r_count);
                        end
                        r_state      <= ST_IDLE;
                        r_hold_valid <= 1'b0;
                        r_count      <= '0;
                        r_err        <= 1'b0;
                    end else begin
                        r_err   <= r_err | w_er;
                        r_state <= ST_DATA;
                        if (w_byte_valid) begin
                            if (r_hold_valid) begin
                                o_rx_data  <= r_hold;
                                o_rx_valid <= 1'b1;
                                r_count    <= sat_inc(r_count);
                            end
                            r_hold       <= w_byte;
                            r_hold_valid <= 1'b1;
                            // Limit byte stays in the hold buffer and is flushed
                            // from DROP next cycle as the errored end byte.
                            if (w_index == 17'(P_MAX_LEN)) r_state <= ST_DROP;
                        end
                    end
                end

                ST_DROP: begin
                    if (r_hold_valid) begin
                        o_rx_data    <= r_hold;
                        o_rx_valid   <= 1'b1;
                        o_rx_end     <= 1'b1;
                        o_rx_err     <= 1'b1;
                        o_rx_len     <= sat_inc(r_count);
                        r_hold_valid <= 1'b0;
                    end
                    r_count <= '0;
                    if (!w_dv) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b0;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef RGMII_INBAND_STATUS_EN
    logic [3:0] r_stat_prev;
    logic       r_stat_seen;

    // Status nibble is accepted only when two consecutive qualifying idle
    // samples agree, so a single glitched cycle never reaches the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_prev   <= '0;
            r_stat_seen   <= 1'b0;
            o_link_up     <= 1'b0;
            o_link_speed  <= SPEED_10;
            o_full_duplex <= 1'b0;
        end else if (r_state == ST_IDLE && !w_dv && !w_er) begin
            r_stat_prev <= i_rxd_rise;
            r_stat_seen <= 1'b1;
            if (r_stat_seen && r_stat_prev == i_rxd_rise) begin
                o_link_up     <= i_rxd_rise[0];
                o_link_speed  <= i_rxd_rise[2:1];
                o_full_duplex <= i_rxd_rise[3];
            end
        end else begin
            r_stat_seen <= 1'b0;
        end
    end
`else
    assign o_link_up     = 1'b0;
    assign o_link_speed  = SPEED_10;
    assign o_full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb_rgmii_rx_decoder
//   Two decoders (default limit and P_MAX_LEN=64) share one RGMII stimulus
//   stream. Each frame is described as a byte list; a reference model derives
//   the delivered bytes, end, err and len per instance and queues them; one
//   monitor per instance pops and compares whenever o_rx_valid is seen.
module tb_rgmii_rx_decoder;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        err;
        logic [15:0] len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spd = 1'b1;
    logic [3:0] rxd_r = '0;
    logic [3:0] rxd_f = '0;
    logic       ctl_r = 1'b0;
    logic       ctl_f = 1'b0;

    logic [7:0]  d_data,  l_data;
    logic        d_valid, l_valid;
    logic        d_end,   l_end;
    logic        d_err,   l_err;
    logic [15:0] d_len,   l_len;
    logic        d_link,  l_link;
    logic [1:0]  d_lspd,  l_lspd;
    logic        d_dup,   l_dup;

    int checks = 0;
    int errors = 0;

    exp_t       q_d[$];
    exp_t       q_l[$];
    logic [7:0] stream[$];

    always #5 clk = ~clk;

    rgmii_rx_decoder u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_speed1000(spd),
        .i_rxd_rise(rxd_r), .i_rxd_fall(rxd_f),
        .i_rxctl_rise(ctl_r), .i_rxctl_fall(ctl_f),
        .o_rx_data(d_data), .o_rx_valid(d_valid), .o_rx_end(d_end),
        .o_rx_err(d_err), .o_rx_len(d_len),
        .o_link_up(d_link), .o_link_speed(d_lspd), .o_full_duplex(d_dup)
    );

    rgmii_rx_decoder #(.P_MAX_LEN(64)) u_lim (
        .i_clk(clk), .i_rst_n(rst_n), .i_speed1000(spd),
        .i_rxd_rise(rxd_r), .i_rxd_fall(rxd_f),
        .i_rxctl_rise(ctl_r), .i_rxctl_fall(ctl_f),
        .o_rx_data(l_data), .o_rx_valid(l_valid), .o_rx_end(l_end),
        .o_rx_err(l_err), .o_rx_len(l_len),
        .o_link_up(l_link), .o_link_speed(l_lspd), .o_full_duplex(l_dup)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && d_valid) begin
            if (q_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut_unexpected actual=%0h required=no_output", d_data);
            end else begin
                e = q_d.pop_front();
                cmp("dut_data", 32'(d_data), 32'(e.data));
                cmp("dut_end", 32'(d_end), 32'(e.last));
                if (e.last) begin
                    cmp("dut_err", 32'(d_err), 32'(e.err));
                    cmp("dut_len", 32'(d_len), 32'(e.len));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && l_valid) begin
            if (q_l.size() == 0) begin
                checks++; errors++;
                $display("FAIL lim_unexpected actual=%0h required=no_output", l_data);
            end else begin
                e = q_l.pop_front();
                cmp("lim_data", 32'(l_data), 32'(e.data));
                cmp("lim_end", 32'(l_end), 32'(e.last));
                if (e.last) begin
                    cmp("lim_err", 32'(l_err), 32'(e.err));
                    cmp("lim_len", 32'(l_len), 32'(e.len));
                end
            end
        end
    end

    // Reference model: walk the stream for the SFD, then deliver payload
    // bytes truncated at the instance limit.
    task automatic push_expected(input bit m100, input bit er_any, input bit odd);
        int   start;
        int   n;
        int   lim;
        int   cnt;
        bit   bad;
        exp_t e;
        start = -1;
        for (int i = 0; i < stream.size(); i++) begin
            if (stream[i] == 8'hD5) begin
                start = i + 1;
                break;
            end else if (stream[i] != 8'h55) begin
                break;
            end
        end
        if (start < 0) return;
        n = stream.size() - start;
        for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? 1522 : 64;
            cnt = (n >= lim) ? lim : n;
            bad = (n >= lim) || er_any || (m100 && odd);
            for (int j = 0; j < cnt; j++) begin
                e.data = stream[start + j];
                e.last = (j == cnt - 1);
                e.err  = e.last && bad;
                e.len  = e.last ? 16'(cnt) : 16'd0;
                if (k == 0) q_d.push_back(e);
                else        q_l.push_back(e);
            end
        end
    endtask

    task automatic cyc(input logic dv, input logic er, input logic [3:0] r,
                       input logic [3:0] f, input logic sp);
        ctl_r = dv;
        ctl_f = dv ^ er;
        rxd_r = r;
        rxd_f = f;
        spd   = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit m100, input int er_idx, input bit odd,
                              input int gap, input bit rand_spd);
        logic sp;
        logic e;
        push_expected(m100, er_idx >= 0, odd);
        for (int i = 0; i < stream.size(); i++) begin
            e  = (i == er_idx);
            sp = (i > 0 && rand_spd) ? logic'($urandom_range(0, 1)) : ~m100;
            if (!m100) begin
                cyc(1'b1, e, stream[i][3:0], stream[i][7:4], sp);
            end else begin
                cyc(1'b1, e, stream[i][3:0], 4'($urandom_range(0, 15)), sp);
                sp = rand_spd ? logic'($urandom_range(0, 1)) : ~m100;
                cyc(1'b1, e, stream[i][7:4], 4'($urandom_range(0, 15)), sp);
            end
        end
        if (m100 && odd) cyc(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'd0, 1'b0);
        repeat (gap) cyc(1'b0, 1'b0, 4'd0, 4'd0, ~m100);
    endtask

    task automatic build(input int pre, input int first, input int len);
        stream.delete();
        repeat (pre) stream.push_back(8'h55);
        stream.push_back(8'hD5);
        for (int i = 0; i < len; i++) stream.push_back(8'(first + i));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_d.size() != 0 || q_l.size() != 0) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (q_d.size() != 0 || q_l.size() != 0) begin
            errors++;
            $display("FAIL drain pending dut=%0d lim=%0d required=0", q_d.size(), q_l.size());
        end
    endtask

    task automatic check_quiet(input string tag);
        cmp({tag, "_d_valid"}, 32'(d_valid), 32'd0);
        cmp({tag, "_d_end"},   32'(d_end),   32'd0);
        cmp({tag, "_d_err"},   32'(d_err),   32'd0);
        cmp({tag, "_d_data"},  32'(d_data),  32'd0);
        cmp({tag, "_d_len"},   32'(d_len),   32'd0);
        cmp({tag, "_l_valid"}, 32'(l_valid), 32'd0);
        cmp({tag, "_l_len"},   32'(l_len),   32'd0);
        cmp({tag, "_status"},  32'({d_link, d_lspd, d_dup}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d required=finish", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int   m100;
        int   pre;
        int   len;
        int   er_idx;
        int   odd;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

        // 1000: 7x55, D5, 01..40
        build(7, 1, 64);
        send_frame(0, -1, 0, 3, 0);
        // 100: nibble stream 5,5 x7 / 5,D / 1,0,2,0
        build(7, 1, 2);
        send_frame(1, -1, 0, 3, 0);
        // 1000: er on 10th data byte of 64
        build(7, 8'h80, 64);
        send_frame(0, 8 + 9, 0, 3, 0);
        // 1000: 100-byte frame, truncated by the 64-byte instance
        build(7, 8'h10, 100);
        send_frame(0, -1, 0, 3, 0);
        build(3, 8'hE0, 8);
        send_frame(0, -1, 0, 3, 0);
        // bad preamble, then a good frame
        stream.delete();
        stream.push_back(8'h55); stream.push_back(8'h55); stream.push_back(8'hAA);
        for (int i = 0; i < 10; i++) stream.push_back(8'(i + 1));
        send_frame(0, -1, 0, 3, 0);
        build(7, 8'h30, 12);
        send_frame(0, -1, 0, 3, 0);
        // 100: odd trailing nibble
        build(7, 8'h40, 5);
        send_frame(1, -1, 1, 3, 0);
        // back-to-back frames (single idle cycle), speed wiggled mid-frame
        build(2, 8'h20, 9);
        send_frame(0, -1, 0, 1, 1);
        build(2, 8'h60, 7);
        send_frame(1, -1, 0, 1, 1);
        build(1, 8'h70, 3);
        send_frame(0, -1, 0, 2, 0);

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            m100 = int'($urandom_range(0, 1));
            pre  = int'($urandom_range(1, 7));
            len  = int'($urandom_range(1, 100));
            stream.delete();
            repeat (pre) stream.push_back(8'h55);
            if ($urandom_range(0, 7) == 0) stream.push_back(8'($urandom_range(0, 8'h54)));
            stream.push_back(8'hD5);
            for (int i = 0; i < len; i++) stream.push_back(8'($urandom_range(0, 255)));
            er_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, stream.size() - 1)) : -1;
            odd    = (m100 != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            send_frame(m100 != 0, er_idx, odd != 0, int'($urandom_range(1, 4)),
                       $urandom_range(0, 1) != 0);
        end
        drain();

        // reset in mid-frame; a complete-looking frame continues with dv high
        // after release and must be ignored until dv drops
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h5, 4'h5, 1'b1);
        rst_n = 1'b0;
        #2;
        check_quiet("midreset");
        cyc(1'b1, 1'b0, 4'h5, 4'h5, 1'b1);
        cyc(1'b1, 1'b0, 4'h5, 4'h5, 1'b1);
        rst_n = 1'b1;
        build(2, 1, 6);
        for (int i = 0; i < stream.size(); i++) cyc(1'b1, 1'b0, stream[i][3:0], stream[i][7:4], 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        build(7, 8'hA0, 6);
        send_frame(0, -1, 0, 3, 0);
        drain();

`ifdef RGMII_INBAND_STATUS_EN
        cyc(1'b0, 1'b0, 4'b1101, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 4'b1101, 4'd0, 1'b1);
        cmp("status_link", 32'(d_link), 32'd1);
        cmp("status_speed", 32'(d_lspd), 32'd2);
        cmp("status_duplex", 32'(d_dup), 32'd1);
        cyc(1'b0, 1'b0, 4'b0010, 4'd0, 1'b1);
        cmp("glitch_status", 32'({d_link, d_lspd, d_dup}), 32'b1101);
        cyc(1'b0, 1'b0, 4'b1101, 4'd0, 1'b1);
        cmp("glitch_recover", 32'({d_link, d_lspd, d_dup}), 32'b1101);
`else
        cyc(1'b0, 1'b0, 4'b1101, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 4'b1101, 4'd0, 1'b1);
        cmp("status_tied", 32'({d_link, d_lspd, d_dup}), 32'd0);
        cmp("status_tied_lim", 32'({l_link, l_lspd, l_dup}), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_decoder.md
RGMII_RX_DECODER -- requirements
Module: rgmii_rx_decoder

Interface
REQ-001 SHALL have parameter P_STRIP_PREAMBLE, default 1; 1 = drop preamble/SFD bytes, 0 = pass all bytes from DV rise.
REQ-002 SHALL have parameter P_MAX_LEN, default 1522; maximum delivered frame bytes, range 64..65535.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports:
- i_clk, input, 1, RX clock; IDDR outputs are synchronous to it.
- i_rst_n, input, 1, async active-low reset.
- i_speed1000, input, 1, 1 = 1000 (byte per cycle), 0 = 10/100 (nibble per cycle).
- i_rxd_rise, input, 4, nibble captured on the rising edge.
- i_rxd_fall, input, 4, nibble captured on the falling edge.
- i_rxctl_rise, input, 1, RX_DV.
- i_rxctl_fall, input, 1, RX_DV xor RX_ER.
- o_rx_data, output, 8, frame byte.
- o_rx_valid, output, 1, o_rx_data valid.
- o_rx_end, output, 1, last byte of frame, coincident with o_rx_valid.
- o_rx_err, output, 1, frame bad; valid only with o_rx_end.
- o_rx_len, output, 16, delivered byte count; valid only with o_rx_end.
- o_link_up, output, 1, in-band link status.
- o_link_speed, output, 2, in-band speed: 00 = 10, 01 = 100, 10 = 1000.
- o_full_duplex, output, 1, in-band duplex.

Function
REQ-005 SHALL compute dv = i_rxctl_rise and er = i_rxctl_rise ^ i_rxctl_fall every cycle.
REQ-006 In 1000 mode, SHALL form byte = {i_rxd_fall, i_rxd_rise} on each dv=1 cycle.
REQ-007 In 10/100 mode, SHALL pack i_rxd_rise nibbles low-first; first nibble after dv rise is the low nibble; a byte completes every 2nd dv cycle.
REQ-008 Frame FSM SHALL have states IDLE, PREAMBLE, DATA, DROP.
- IDLE -> PREAMBLE on dv=1 when P_STRIP_PREAMBLE=1; otherwise IDLE -> DATA.
- PREAMBLE: 0x55 bytes are discarded; 0xD5 -> DATA; any other byte -> DROP.
- DATA -> IDLE on dv=0.
- DROP -> IDLE on dv=0; no output is produced in DROP.
REQ-009 SHALL buffer one byte. Byte k is emitted (o_rx_valid=1) in the cycle after byte k+1 completes, or after dv=0 is sampled; in the latter case o_rx_end=1.
REQ-010 o_rx_err SHALL be 1 with o_rx_end if any of:
- er=1 was sampled during the frame;
- in 10/100 mode, dv fell with an odd nibble count (trailing nibble discarded);
- the length limit was hit (REQ-012).
REQ-011 o_rx_len SHALL equal the number of bytes delivered including the end byte; counter width 16, saturating.
REQ-012 When byte P_MAX_LEN is delivered, it SHALL carry o_rx_end=1 and o_rx_err=1; FSM -> DROP.
REQ-013 dv=1 in the cycle after dv falls SHALL start a new frame; the end byte of the previous frame SHALL still be emitted.
REQ-014 A PREAMBLE-to-IDLE exit (dv falls before SFD) SHALL produce no output.
REQ-015 Change of i_speed1000 SHALL take effect only in IDLE.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 During reset, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the hold buffer, nibble phase and counters SHALL be cleared.
REQ-018 Reset assertion mid-frame SHALL abandon the frame. After release, the FSM SHALL wait for dv=0 before accepting a new frame.

Configuration
REQ-019 Macro RGMII_INBAND_STATUS_EN.
- Defined: in IDLE with dv=0 and er=0, decode i_rxd_rise as [0] = link, [2:1] = speed, [3] = duplex. Status outputs update only after two consecutive identical samples.
- Undefined: o_link_up, o_link_speed and o_full_duplex are tied to 0.

Structure
REQ-020 Package rgmii_pkg SHALL hold the FSM state enum, speed codes, and constants PREAMBLE_BYTE = 8'h55 and SFD_BYTE = 8'hD5.
REQ-021 Nibble packing (REQ-006/007) SHALL be in sub-module rgmii_nibble_packer.

Verification
REQ-022 1000 mode, P_STRIP_PREAMBLE=1, input 7x55, D5, 01..40 (64 bytes), then dv=0 -> 64 valid bytes 01..40; end on 0x40; len=64; err=0.
REQ-023 100 mode, input nibbles 5,5 x7, 5,D, then 1,0,2,0 -> bytes 0x01, 0x02; end on 0x02; len=2; err=0.
REQ-024 1000 mode, er pulse on the 10th data byte of a 64-byte frame -> all 64 bytes delivered; err=1 on the end byte.
REQ-025 1000 mode, P_MAX_LEN=64, 100-byte frame -> 64 bytes delivered, end+err on byte 64, nothing further until the next frame.
REQ-026 1000 mode, preamble 55,55,AA -> no output; next good frame delivered normally.
REQ-027 With RGMII_INBAND_STATUS_EN, idle rxd=4'b1101 for 2 cycles -> o_link_up=1, o_link_speed=10, o_full_duplex=1; a single-cycle glitch -> no change.
